// File: rtl/io_timer.sv
// Memory-mapped prescaled down-counter timer with level interrupt on the CPU data bus.
// Optional overrun flag STATUS[1] is built only when TIMER_OVERRUN_EN is defined.
module io_timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        oe,
  input  logic [15:0] Direcciones,
  inout  wire  [15:0] Datos,
  output logic        intr_req
);

  logic        r_en;
  logic        r_auto;
  logic        r_irq_en;
  logic [7:0]  r_presc;
  logic [15:0] r_reload;
  logic [15:0] r_count;
  logic [7:0]  r_pre;
  logic        r_exp;

  logic [15:0] w_off;
  logic        w_hit;
  logic        w_wr;
  logic        w_rd;
  logic [15:0] w_wdata;
  logic        w_wr_ctrl;
  logic        w_wr_reload;
  logic        w_wr_status;
  logic        w_start;
  logic        w_tick;
  logic        w_expire;
  logic        w_ovr;
  logic [15:0] w_rdata;

  // Window decode by offset so a window near the top of the map cannot alias.
  assign w_off       = Direcciones - BASE_ADDR;
  assign w_hit       = (w_off[15:2] == 14'd0);
  assign w_wr        = oe & w_hit;
  assign w_rd        = ~oe & w_hit;
  assign w_wdata     = Datos;
  assign w_wr_ctrl   = w_wr & (w_off[1:0] == 2'd0);
  assign w_wr_reload = w_wr & (w_off[1:0] == 2'd1);
  assign w_wr_status = w_wr & (w_off[1:0] == 2'd3);

  assign w_start  = w_wr_ctrl & w_wdata[0] & ~r_en;
  assign w_tick   = r_en & (r_pre == r_presc);
  assign w_expire = w_tick & (r_count == 16'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_irq_en <= 1'b0;
      r_presc  <= 8'd0;
      r_reload <= 16'd0;
      r_count  <= 16'd0;
      r_pre    <= 8'd0;
      r_exp    <= 1'b0;
    end else begin
      // A CTRL write overrides the one-shot self-disable in the same cycle.
      if (w_wr_ctrl) begin
        r_en     <= w_wdata[0];
        r_auto   <= w_wdata[1];
        r_irq_en <= w_wdata[2];
        r_presc  <= w_wdata[15:8];
      end else if (w_expire && !r_auto) begin
        r_en <= 1'b0;
      end

      if (w_wr_reload)
        r_reload <= w_wdata;

      if (w_start) begin
        r_count <= r_reload;
        r_pre   <= 8'd0;
      end else if (r_en) begin
        r_pre <= w_tick ? 8'd0 : r_pre + 8'd1;
        if (w_tick) begin
          if (r_count != 16'd0)
            r_count <= r_count - 16'd1;
          else if (r_auto)
            r_count <= r_reload;
        end
      end

      r_exp <= w_expire | (r_exp & ~(w_wr_status & w_wdata[0]));
    end
  end

`ifdef TIMER_OVERRUN_EN
  logic r_ovr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_ovr <= 1'b0;
    else
      r_ovr <= (w_expire & r_exp) | (r_ovr & ~(w_wr_status & w_wdata[1]));
  end

  assign w_ovr = r_ovr;
`else
  assign w_ovr = 1'b0;
`endif

  always_comb begin
    w_rdata = 16'd0;
    case (w_off[1:0])
      2'd0:    w_rdata = {r_presc, 5'd0, r_irq_en, r_auto, r_en};
      2'd1:    w_rdata = r_reload;
      2'd2:    w_rdata = r_count;
      default: w_rdata = {14'd0, w_ovr, r_exp};
    endcase
  end

  assign Datos    = w_rd ? w_rdata : 16'bz;
  assign intr_req = r_exp & r_irq_en;

endmodule

// File: tb/tb_io_timer.sv
// Directed and randomized bench for io_timer against a rule-level timer model.
module tb_io_timer;

  localparam logic [15:0] BASE = 16'hFF00;
`ifdef TIMER_OVERRUN_EN
  localparam bit OVR_ON = 1'b1;
`else
  localparam bit OVR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        oe = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] dout = 16'h0000;
  logic        drv = 1'b0;
  wire  [15:0] Datos;
  logic        intr_req;

  assign Datos = drv ? dout : 16'bz;

  io_timer #(.BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .oe          (oe),
    .Direcciones (addr),
    .Datos       (Datos),
    .intr_req    (intr_req)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic        m_en, m_auto, m_irq, m_exp, m_ovr;
  logic [7:0]  m_presc, m_pre;
  logic [15:0] m_reload, m_count;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
    n_chk++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, req);
    end
  endtask

  task automatic m_reset();
    m_en = 0; m_auto = 0; m_irq = 0; m_exp = 0; m_ovr = 0;
    m_presc = 0; m_pre = 0; m_reload = 0; m_count = 0;
  endtask

  function automatic logic [15:0] m_read(input logic [1:0] off);
    case (off)
      2'd0:    return {m_presc, 5'd0, m_irq, m_auto, m_en};
      2'd1:    return m_reload;
      2'd2:    return m_count;
      default: return {14'd0, m_ovr, m_exp};
    endcase
  endfunction

  // Advance the model by one clock edge given the bus cycle presented.
  task automatic m_edge(input logic o, input logic [15:0] a, input logic [15:0] d);
    int          off;
    bit          wr, tick, expire, ovr_set, en0;
    logic [15:0] reload0;
    if (!reset) begin
      m_reset();
      return;
    end
    off     = int'(a) - int'(BASE);
    wr      = o && (off >= 0) && (off <= 3);
    en0     = m_en;
    reload0 = m_reload;
    tick    = m_en && (m_pre == m_presc);
    expire  = tick && (m_count == 0);
    ovr_set = OVR_ON && expire && m_exp;
    if (m_en) m_pre = tick ? 8'd0 : m_pre + 8'd1;
    if (tick) begin
      if (m_count != 0) m_count = m_count - 1;
      else if (m_auto) m_count = m_reload;
      else m_en = 0;
    end
    if (expire) m_exp = 1;
    if (ovr_set) m_ovr = 1;
    if (wr) begin
      case (off)
        0: begin
          if (!en0 && d[0]) begin
            m_count = reload0;
            m_pre = 0;
          end
          m_en = d[0]; m_auto = d[1]; m_irq = d[2]; m_presc = d[15:8];
        end
        1: m_reload = d;
        3: begin
          if (d[0] && !expire) m_exp = 0;
          if (d[1] && !ovr_set) m_ovr = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic o, input logic [15:0] a, input logic [15:0] d, input logic tbdrv);
    @(negedge clk);
    oe = o; addr = a; dout = d; drv = tbdrv;
    @(posedge clk);
    m_edge(o, a, d);
    #1 chk("intr_req", {15'd0, intr_req}, {15'd0, m_exp & m_irq});
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cyc(1'b1, a, d, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    logic [15:0] off;
    off = a - BASE;
    @(negedge clk);
    oe = 0; addr = a; drv = 0;
    #1 v = Datos;
    chk("read vs model", v, m_read(off[1:0]));
    @(posedge clk);
    m_edge(1'b0, a, 16'h0000);
    #1 chk("intr_req", {15'd0, intr_req}, {15'd0, m_exp & m_irq});
  endtask

  // The bench drives a pattern; the bus must carry it unaltered when the timer stays off it.
  task automatic probe(input logic o, input logic [15:0] a);
    @(negedge clk);
    oe = o; addr = a; dout = 16'h5A5A; drv = 1;
    #1 chk("bus not driven", Datos, 16'h5A5A);
    @(posedge clk);
    m_edge(o, a, 16'h5A5A);
    #1 chk("intr_req", {15'd0, intr_req}, {15'd0, m_exp & m_irq});
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset = 0;
    m_reset();
    #1 chk("reset intr_req", {15'd0, intr_req}, 16'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    int n;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1;

    // Reset in the middle of a running count
    wr(BASE + 1, 16'd100);
    wr(BASE, 16'h0001);
    repeat (20) idle();
    async_reset();
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 16'(i), v);
      chk("reset reg", v, 16'h0000);
    end
    probe(1'b0, 16'h1234);
    @(negedge clk);
    reset = 1;

    // One-shot expiry and software clear
    wr(BASE + 1, 16'd3);
    wr(BASE, 16'h0005);
    repeat (3) begin
      idle();
      chk("oneshot early", {15'd0, intr_req}, 16'd0);
    end
    idle();
    chk("oneshot irq", {15'd0, intr_req}, 16'd1);
    rd(BASE, v);      chk("oneshot ctrl", v, 16'h0004);
    rd(BASE + 2, v);  chk("oneshot count", v, 16'h0000);
    rd(BASE + 3, v);  chk("oneshot status", v, 16'h0001);
    wr(BASE + 3, 16'h0001);
    chk("oneshot clear", {15'd0, intr_req}, 16'd0);

    // Periodic with prescaler 3, reload 2
    wr(BASE + 1, 16'd2);
    wr(BASE, 16'h0303);
    for (int i = 0; i < 12; i++) begin
      rd(BASE + 2, v);
      chk("periodic count", v, 16'(2 - i / 4));
    end
    rd(BASE + 3, v);  chk("periodic exp", v, 16'h0001);
    chk("periodic no irq", {15'd0, intr_req}, 16'd0);
    rd(BASE + 2, v);  chk("periodic reload", v, 16'd2);

    // Clear and expiry colliding every cycle
    wr(BASE, 16'h0000);
    wr(BASE + 3, 16'h0003);
    wr(BASE + 1, 16'h0000);
    wr(BASE, 16'h0003);
    repeat (6) wr(BASE + 3, 16'h0001);
    rd(BASE + 3, v);
    chk("collision status", v, OVR_ON ? 16'h0003 : 16'h0001);

    // Address decode
    wr(BASE, 16'h0000);
    wr(BASE + 3, 16'h0003);
    wr(16'hFF01, 16'hABCD);
    wr(16'hFF04, 16'h1234);
    rd(16'hFF01, v);  chk("decode reload", v, 16'hABCD);
    rd(16'hFF00, v);  chk("decode ctrl", v, 16'h0000);
    probe(1'b1, 16'hFF02);
    rd(16'hFF02, v);  chk("count write ignored", v, 16'h0000);
    probe(1'b0, 16'hFEFF);
    probe(1'b0, 16'hFF04);

    // Live reload change
    wr(BASE + 3, 16'h0003);
    wr(BASE + 1, 16'd5);
    wr(BASE, 16'h0007);
    idle();
    idle();
    wr(BASE + 1, 16'd1);
    n = 3;
    while (!intr_req && n < 50) begin
      idle();
      n++;
    end
    chk("live period1", 16'(n), 16'd6);
    wr(BASE + 3, 16'h0001);
    n = 1;
    while (!intr_req && n < 50) begin
      idle();
      n++;
    end
    chk("live period2", 16'(n), 16'd2);

    // Randomized bus traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        async_reset();
        rd(BASE + 16'($urandom_range(0, 3)), v);
        @(negedge clk);
        reset = 1;
      end
      case ($urandom_range(0, 9))
        0: wr(BASE, {8'($urandom_range(0, 3)), 5'd0, 3'($urandom)});
        1: wr(BASE + 1, 16'($urandom_range(0, 7)));
        2: wr(BASE + 3, {14'd0, 2'($urandom)});
        3: wr(BASE + 2, 16'($urandom));
        4, 5, 6: rd(BASE + 16'($urandom_range(0, 3)), v);
        7: probe(1'($urandom), $urandom_range(0, 1) ? 16'(16'hFF04 + $urandom_range(0, 16'hFB))
                                                   : 16'($urandom_range(0, 16'hFEFF)));
        default: idle();
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
